epcs_read_sequencer: RTL
========================

// Module: epcs_read_sequencer
// PURPOSE
// - Hardware sequencer for the EPCS SPI master's register port. It performs a
//   serial-flash READ (opcode, 24-bit address, N data bytes) with no CPU help.
// - Sits between the boot/DMA logic and the EPCS control port. It is the sole
//   Avalon master on that port while busy.
// - Received bytes leave on an 8-bit valid/ready stream.
// PARAMETERS
// - READ_OPCODE  8'h03    flash read command byte
// - CSR_BASE     9'h100   register-space base on the SPI port (address[8]=1)
// - SS_MASK      16'h0001 value written to slave-select register (addr 5)
// - POLL_LIMIT   1024     max status polls per wait before timeout
// PORTS
// - clk          in   1   system clock
// - reset_n      in   1   asynchronous active-low reset
// - start        in   1   1-cycle request; accepted only when busy=0
// - flash_addr   in   24  flash byte address, captured on accepted start
// - byte_count   in   16  data bytes to read, captured on accepted start
// - busy         out  1   high from accept until done
// - done         out  1   1-cycle pulse at end of request (success or error)
// - error        out  1   status of last request; TOE/ROE seen or poll timeout
// - out_data     out  8   received data byte
// - out_valid    out  1   out_data valid; held until out_ready
// - out_ready    in   1   sink accepts byte when out_valid & out_ready
// - avm_address  out  9   CSR_BASE + register index (0 rx,1 tx,2 status,3 ctl,5 ss)
// - avm_chipselect out 1  access active
// - avm_read_n   out  1   active-low read
// - avm_write_n  out  1   active-low write
// - avm_writedata out 32  write data; upper bits 0
// - avm_readdata in   32  read data from SPI port
// BEHAVIOUR
// - Reset values: busy=0, done=0, error=0, out_valid=0, out_data=0,
//   avm_chipselect=0, avm_read_n=1, avm_write_n=1, avm_address=0,
//   avm_writedata=0.
// - Bus access: strobes held exactly 2 cycles. Read data is sampled at the end
//   of cycle 2. Between accesses, at least 1 idle cycle with all strobes
//   inactive.
// - FSM: IDLE -> SS_WR (ss=SS_MASK) -> CTL_ON (ctl=bit10 SSO) -> per byte:
//   POLL_TX (read status until TRDY bit6) -> WR_TX -> POLL_RX (read status
//   until RRDY bit7) -> RD_RX -> [PUSH] -> next byte or CTL_OFF (ctl=0) -> DONE
//   -> IDLE.
// - Byte sequence: READ_OPCODE, addr[23:16], addr[15:8], addr[7:0], then
//   byte_count bytes of 8'h00.
// - The 4 header rx bytes are read (clears RRDY) and discarded. Data rx bytes go
//   to PUSH, where out_valid stays high until out_ready. The next tx write is
//   not issued before that handshake.
// - byte_count=0: no bus accesses. done pulses 2 cycles after start; error=0.
// - A status read with TOE(bit4) or ROE(bit3) set is an error. So is a poll
//   count reaching POLL_LIMIT.
// - On error: jump to CTL_OFF (SSO released), set error, pulse done. Any
//   pending out_valid is dropped.
// - A start while busy is ignored. error is cleared on the next accepted start.
// - done and busy=0 occur in the same cycle as the DONE->IDLE transition.
// - Poll counter: 10 bits, saturating compare, reset at each new wait.
// - Byte counter: 17 bits, counts header + data bytes, no wrap.
// - Asynchronous reset mid-transfer returns to IDLE with reset values. The SPI
//   core is reset by the same reset_n.
// STRUCTURE
// - Shared package: SPI register indices, status/control bit positions, FSM
//   state enum.
// - Sub-module: epcs_csr_access. It runs a single 2-cycle read or write plus the
//   idle gap, and reports ack with rdata. The top FSM only issues req/we/idx/wdata.
// TESTING (bench: epcs SPI core + flash behavioural model on sdo/dclk/sce/data0)
// - start, addr=24'h012345, count=4 -> MOSI 03 01 23 45 00x4; 4 model bytes
//   streamed; done; error=0.
// - count=0 -> no avm activity; done 2 cycles after start; busy 1 cycle.
// - out_ready low 50 cycles on byte 2 -> out_valid/out_data stable; no tx
//   write issued; all bytes arrive in order.
// - Force TOE in status -> SSO cleared, error=1, done pulse; next start clears
//   error.
// - Hold status TRDY=0 (stub) -> timeout after 1024 polls -> error=1, done.
// - start pulsed while busy; reset asserted mid-byte -> start ignored; after
//   reset all outputs at reset values, sce=1.

Source files
------------

// File: rtl/epcs_read_sequencer_pkg.sv
// Shared definitions for the EPCS read sequencer: SPI register map, status/control bits,
// state encodings and the command-byte helper.
package epcs_read_sequencer_pkg;

    localparam logic [2:0] REG_RX     = 3'd0;
    localparam logic [2:0] REG_TX     = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTL    = 3'd3;
    localparam logic [2:0] REG_SS     = 3'd5;

    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 4;
    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;
    localparam int CTL_SSO = 10;

    localparam logic [31:0] CTL_SSO_WORD = 32'h1 << CTL_SSO;
    localparam logic [16:0] HDR_BYTES    = 17'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_SS_WR, S_CTL_ON, S_POLL_TX, S_WR_TX,
        S_POLL_RX, S_RD_RX, S_PUSH, S_CTL_OFF, S_DONE
    } seq_state_t;

    typedef enum logic [1:0] {P_IDLE, P_CYC1, P_CYC2, P_GAP} csr_phase_t;

    // Byte clocked out on MOSI at position idx: opcode, 3 address bytes, then dummies.
    function automatic logic [7:0] tx_byte(input logic [16:0] idx, input logic [7:0] opcode,
                                           input logic [23:0] addr);
        case (idx)
            17'd0:   return opcode;
            17'd1:   return addr[23:16];
            17'd2:   return addr[15:8];
            17'd3:   return addr[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/epcs_csr_access.sv
// One Avalon register access: strobes held 2 cycles, read data sampled at end of cycle 2,
// then a forced idle cycle; ack pulses during that idle cycle. req is taken only when idle.
module epcs_csr_access
    import epcs_read_sequencer_pkg::*;
#(
    parameter logic [8:0] CSR_BASE = 9'h100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  idx,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [8:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_read_n,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    csr_phase_t phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase          <= P_IDLE;
            ack            <= 1'b0;
            rdata          <= '0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_read_n     <= 1'b1;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            ack <= 1'b0;
            case (phase)
                P_IDLE, P_GAP: begin
                    phase <= P_IDLE;
                    if (req) begin
                        phase          <= P_CYC1;
                        avm_address    <= CSR_BASE + {6'd0, idx};
                        avm_chipselect <= 1'b1;
                        avm_read_n     <= we;
                        avm_write_n    <= !we;
                        avm_writedata  <= we ? wdata : 32'd0;
                    end
                end
                P_CYC1: phase <= P_CYC2;
                P_CYC2: begin
                    phase          <= P_GAP;
                    ack            <= 1'b1;
                    if (!avm_read_n) rdata <= avm_readdata;
                    avm_address    <= '0;
                    avm_chipselect <= 1'b0;
                    avm_read_n     <= 1'b1;
                    avm_write_n    <= 1'b1;
                    avm_writedata  <= '0;
                end
                default: phase <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/epcs_read_sequencer.sv
// Autonomous serial-flash READ over the EPCS SPI register port; data bytes leave on a
// valid/ready stream and the next tx write waits for each byte's handshake.
module epcs_read_sequencer
    import epcs_read_sequencer_pkg::*;
#(
    parameter logic [7:0]  READ_OPCODE = 8'h03,
    parameter logic [8:0]  CSR_BASE    = 9'h100,
    parameter logic [15:0] SS_MASK     = 16'h0001,
    parameter int          POLL_LIMIT  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] flash_addr,
    input  logic [15:0] byte_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [8:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_read_n,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    localparam logic [9:0] POLL_LAST = 10'(POLL_LIMIT - 1);

    seq_state_t  state;
    logic [23:0] addr_q;
    logic [16:0] total_q;
    logic [16:0] byte_cnt;
    logic [9:0]  poll_cnt;
    logic        req;
    logic        we;
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        status_err;
    logic        poll_expired;
    logic [16:0] next_cnt;
    logic        last_byte;

    assign status_err   = rdata[ST_TOE] | rdata[ST_ROE];
    assign poll_expired = (poll_cnt == POLL_LAST);
    assign next_cnt     = byte_cnt + 17'd1;
    assign last_byte    = (next_cnt == total_q);

    epcs_csr_access #(.CSR_BASE(CSR_BASE)) u_csr (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .we             (we),
        .idx            (idx),
        .wdata          (wdata),
        .ack            (ack),
        .rdata          (rdata),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_read_n     (avm_read_n),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            addr_q    <= '0;
            total_q   <= '0;
            byte_cnt  <= '0;
            poll_cnt  <= '0;
            req       <= 1'b0;
            we        <= 1'b0;
            idx       <= '0;
            wdata     <= '0;
        end else begin
            done <= 1'b0;
            req  <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    addr_q   <= flash_addr;
                    total_q  <= {1'b0, byte_count} + HDR_BYTES;
                    byte_cnt <= '0;
                    error    <= 1'b0;
                    busy     <= 1'b1;
                    if (byte_count == 16'd0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_SS_WR;
                        req <= 1'b1; we <= 1'b1; idx <= REG_SS; wdata <= {16'd0, SS_MASK};
                    end
                end
                S_SS_WR: if (ack) begin
                    state <= S_CTL_ON;
                    req <= 1'b1; we <= 1'b1; idx <= REG_CTL; wdata <= CTL_SSO_WORD;
                end
                S_CTL_ON: if (ack) begin
                    state    <= S_POLL_TX;
                    poll_cnt <= '0;
                    req <= 1'b1; we <= 1'b0; idx <= REG_STATUS; wdata <= '0;
                end
                S_POLL_TX: if (ack) begin
                    if (status_err || (!rdata[ST_TRDY] && poll_expired)) begin
                        state <= S_CTL_OFF; error <= 1'b1; out_valid <= 1'b0;
                        req <= 1'b1; we <= 1'b1; idx <= REG_CTL; wdata <= '0;
                    end else if (rdata[ST_TRDY]) begin
                        state <= S_WR_TX;
                        req <= 1'b1; we <= 1'b1; idx <= REG_TX;
                        wdata <= {24'd0, tx_byte(byte_cnt, READ_OPCODE, addr_q)};
                    end else begin
                        poll_cnt <= poll_cnt + 10'd1;
                        req <= 1'b1; we <= 1'b0; idx <= REG_STATUS; wdata <= '0;
                    end
                end
                S_WR_TX: if (ack) begin
                    state    <= S_POLL_RX;
                    poll_cnt <= '0;
                    req <= 1'b1; we <= 1'b0; idx <= REG_STATUS; wdata <= '0;
                end
                S_POLL_RX: if (ack) begin
                    if (status_err || (!rdata[ST_RRDY] && poll_expired)) begin
                        state <= S_CTL_OFF; error <= 1'b1; out_valid <= 1'b0;
                        req <= 1'b1; we <= 1'b1; idx <= REG_CTL; wdata <= '0;
                    end else if (rdata[ST_RRDY]) begin
                        state <= S_RD_RX;
                        req <= 1'b1; we <= 1'b0; idx <= REG_RX; wdata <= '0;
                    end else begin
                        poll_cnt <= poll_cnt + 10'd1;
                        req <= 1'b1; we <= 1'b0; idx <= REG_STATUS; wdata <= '0;
                    end
                end
                // Header echo bytes are read only to clear RRDY; data bytes go to the stream.
                S_RD_RX: if (ack) begin
                    if (byte_cnt < HDR_BYTES) begin
                        byte_cnt <= next_cnt;
                        poll_cnt <= '0;
                        if (last_byte) begin
                            state <= S_CTL_OFF;
                            req <= 1'b1; we <= 1'b1; idx <= REG_CTL; wdata <= '0;
                        end else begin
                            state <= S_POLL_TX;
                            req <= 1'b1; we <= 1'b0; idx <= REG_STATUS; wdata <= '0;
                        end
                    end else begin
                        state     <= S_PUSH;
                        out_data  <= rdata[7:0];
                        out_valid <= 1'b1;
                    end
                end
                S_PUSH: if (out_ready) begin
                    out_valid <= 1'b0;
                    byte_cnt  <= next_cnt;
                    poll_cnt  <= '0;
                    if (last_byte) begin
                        state <= S_CTL_OFF;
                        req <= 1'b1; we <= 1'b1; idx <= REG_CTL; wdata <= '0;
                    end else begin
                        state <= S_POLL_TX;
                        req <= 1'b1; we <= 1'b0; idx <= REG_STATUS; wdata <= '0;
                    end
                end
                S_CTL_OFF: if (ack) state <= S_DONE;
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
